// File: rtl/data_pipe_rr_arbiter_m2s_if.sv
// data_inf: valid/ready/data stream bundle shared by every port of the
// many-to-one round-robin arbiter.
//   valid : producer has a beat on data
//   ready : consumer accepts the beat this cycle
//   data  : DSIZE-bit payload
// Modports: master (drives valid/data, samples ready) and
//           slaver (samples valid/data, drives ready).
interface data_inf #(
  parameter int DSIZE = 8
) ();
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (output valid, output data, input ready);
  modport slaver (input valid, input data, output ready);
endinterface

// File: rtl/data_pipe_rr_arbiter_m2s.sv
// data_pipe_rr_arbiter_m2s: round-robin arbiter that merges NUM upstream
// data_inf streams into one downstream stream through a single registered
// stage. A grant is held for a burst. It is released when the owner goes idle
// or when MAX_BURST beats have been taken. The pointer then moves past the
// owner, so the owner has the lowest priority in the next arbitration.
//
// Ports:
//   clock         : rising-edge clock
//   rst           : synchronous active-high reset
//   clk_en        : global enable, freezes all state when low
//   s00[NUM-1:0]  : upstream requesters (data_inf.slaver)
//   m00           : shared downstream stream (data_inf.master)
//   curr_path     : index of the current or last owner
//   curr_path_vld : high while a grant is active
//   burst_cnt     : beats accepted in the current grant
//
// Optional feature, macro DATA_PIPE_ARB_LAST_EN: adds s_last/m_last. A grant
// then ends only on an accepted beat with s_last set. Packets are never split,
// and burst_cnt saturates at 16'hFFFF instead of MAX_BURST.
module data_pipe_rr_arbiter_m2s #(
  parameter int DSIZE     = 8,
  parameter int NUM       = 4,
  parameter int NSIZE     = (NUM > 1) ? $clog2(NUM) : 1,
  parameter int MAX_BURST = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              clk_en,
  data_inf.slaver           s00 [NUM-1:0],
  data_inf.master           m00,
`ifdef DATA_PIPE_ARB_LAST_EN
  input  logic [NUM-1:0]    s_last,
  output logic              m_last,
`endif
  output logic [NSIZE-1:0]  curr_path,
  output logic              curr_path_vld,
  output logic [15:0]       burst_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

`ifdef DATA_PIPE_ARB_LAST_EN
  localparam logic [15:0] CNT_MAX = 16'hFFFF;
`else
  localparam logic [15:0] CNT_MAX = 16'(MAX_BURST);
`endif

  state_t             state_q, state_d;
  logic [NUM-1:0]     req_q, req_d;
  logic [NSIZE-1:0]   ptr_q, ptr_d;
  logic [NSIZE-1:0]   path_q, path_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               mvld_q, mvld_d;
  logic [DSIZE-1:0]   mdata_q, mdata_d;
`ifdef DATA_PIPE_ARB_LAST_EN
  logic               mlast_q, mlast_d;
`endif

  logic [NUM-1:0]     s_valid_s;
  logic [NUM-1:0]     ready_s;
  logic [DSIZE-1:0]   s_data_s [NUM];
  logic [NSIZE-1:0]   winner_s;
  logic               own_valid_s;
  logic               own_ready_s;
  logic               up_beat_s;
  logic               dn_beat_s;
  logic               rel_s;
  logic [15:0]        cnt_inc_s;

  // The interface array is flattened into plain vectors so it can be indexed by path_q.
  for (genvar g = 0; g < NUM; g++) begin : g_ports
    assign s_valid_s[g] = s00[g].valid;
    assign s_data_s[g]  = s00[g].data;
    assign s00[g].ready = ready_s[g];
  end

  // Winner search: first request found from pointer+1 upward, wrapping modulo NUM.
  always_comb begin
    logic found;
    found    = 1'b0;
    winner_s = ptr_q;
    for (int k = 1; k <= NUM; k++) begin
      if (!found && req_q[(int'(ptr_q) + k) % NUM]) begin
        winner_s = NSIZE'((int'(ptr_q) + k) % NUM);
        found    = 1'b1;
      end else begin
        found    = found;
      end
    end
  end

  // Owner handshake and the release decision.
  always_comb begin
    own_valid_s = s_valid_s[path_q];
    // The stage can take a beat when it is empty or is emptying this cycle.
    own_ready_s = !mvld_q || m00.ready;
    ready_s     = '0;
    if (state_q == ST_GRANT) begin
      ready_s[path_q] = own_ready_s;
    end else begin
      ready_s = '0;
    end
    up_beat_s = (state_q == ST_GRANT) && own_valid_s && own_ready_s && clk_en;
    dn_beat_s = mvld_q && m00.ready && clk_en;
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + 16'd1;
    end
`ifdef DATA_PIPE_ARB_LAST_EN
    rel_s = up_beat_s && s_last[path_q];
`else
    if (up_beat_s) begin
      rel_s = (cnt_inc_s == CNT_MAX);
    end else begin
      // Owner idle while it is offered ready: the burst is over.
      rel_s = !own_valid_s && own_ready_s && clk_en;
    end
`endif
  end

  // Next-state, pointer, counter and output-stage logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ptr_d   = ptr_q;
    path_d  = path_q;
    cnt_d   = cnt_q;
    mvld_d  = mvld_q;
    mdata_d = mdata_q;
`ifdef DATA_PIPE_ARB_LAST_EN
    mlast_d = mlast_q;
`endif
    if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          req_d = s_valid_s;
          if (|s_valid_s) begin
            state_d = ST_ARB;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARB: begin
          path_d  = winner_s;
          ptr_d   = winner_s;
          cnt_d   = 16'd0;
          state_d = ST_GRANT;
        end
        ST_GRANT: begin
          if (up_beat_s) begin
            cnt_d = cnt_inc_s;
          end else begin
            cnt_d = cnt_q;
          end
          if (rel_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GRANT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // The output stage drains in every state, so a held beat survives re-arbitration.
      if (up_beat_s) begin
        mvld_d  = 1'b1;
        mdata_d = s_data_s[path_q];
`ifdef DATA_PIPE_ARB_LAST_EN
        mlast_d = s_last[path_q];
`endif
      end else if (dn_beat_s) begin
        mvld_d = 1'b0;
      end else begin
        mvld_d = mvld_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      ptr_q   <= NSIZE'(NUM - 1);
      path_q  <= '0;
      cnt_q   <= 16'd0;
      mvld_q  <= 1'b0;
      mdata_q <= '0;
`ifdef DATA_PIPE_ARB_LAST_EN
      mlast_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ptr_q   <= ptr_d;
      path_q  <= path_d;
      cnt_q   <= cnt_d;
      mvld_q  <= mvld_d;
      mdata_q <= mdata_d;
`ifdef DATA_PIPE_ARB_LAST_EN
      mlast_q <= mlast_d;
`endif
    end
  end

  assign m00.valid     = mvld_q;
  assign m00.data      = mdata_q;
  assign curr_path     = path_q;
  assign curr_path_vld = (state_q == ST_GRANT);
  assign burst_cnt     = cnt_q;
`ifdef DATA_PIPE_ARB_LAST_EN
  assign m_last        = mlast_q;
`endif

endmodule

// File: tb/tb_data_pipe_rr_arbiter_m2s.sv
// Directed bench for data_pipe_rr_arbiter_m2s (NUM=4, DSIZE=8, MAX_BURST=4).
// Each requester owns a queue of beats. Accepted upstream beats go into a
// scoreboard, and downstream beats are popped from it and compared.
module tb_data_pipe_rr_arbiter_m2s;
  localparam int NUM = 4;
  localparam int DW  = 8;

  logic clock = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  always #5 clock = ~clock;

  data_inf #(.DSIZE(DW)) s_if [NUM-1:0] ();
  data_inf #(.DSIZE(DW)) m_if ();

  logic [NUM-1:0] tb_valid, tb_ready;
  logic [DW-1:0]  tb_data [NUM];
  logic           m_ready;
  logic [1:0]     curr_path;
  logic           cpv;
  logic [15:0]    burst_cnt;
`ifdef DATA_PIPE_ARB_LAST_EN
  logic [NUM-1:0] tb_last;
  logic           m_last;
  logic           sb_last [$];
`endif

  for (genvar g = 0; g < NUM; g++) begin : g_src
    assign s_if[g].valid = tb_valid[g];
    assign s_if[g].data  = tb_data[g];
    assign tb_ready[g]   = s_if[g].ready;
  end
  assign m_if.ready = m_ready;

  data_pipe_rr_arbiter_m2s #(.DSIZE(DW), .NUM(NUM), .MAX_BURST(4)) dut (
    .clock(clock), .rst(rst), .clk_en(clk_en), .s00(s_if), .m00(m_if),
`ifdef DATA_PIPE_ARB_LAST_EN
    .s_last(tb_last), .m_last(m_last),
`endif
    .curr_path(curr_path), .curr_path_vld(cpv), .burst_cnt(burst_cnt));

  logic [DW-1:0] src_mem [NUM][32];
  logic          src_lst [NUM][32];
  int            src_head [NUM];
  int            src_len [NUM];
  logic [DW-1:0] sb [$];
  int            own_log [$];
  int            cyc_log [$];
  int            cyc, ndn, nstall, max_bc, total, bad;
  bit            stall_mode, prev_stall;
  logic [DW-1:0] prev_data;
  logic [3:0]    pat = 4'b1001;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int r, input int n, input logic [7:0] base);
    for (int j = 0; j < n; j++) begin
      src_mem[r][src_len[r] + j] = 8'(base + 8'(j));
      src_lst[r][src_len[r] + j] = (j == n - 1);
    end
    src_len[r] += n;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM; i++) begin
      tb_valid[i] = (src_head[i] < src_len[i]);
      tb_data[i]  = tb_valid[i] ? src_mem[i][src_head[i]] : 8'h00;
`ifdef DATA_PIPE_ARB_LAST_EN
      tb_last[i]  = tb_valid[i] ? src_lst[i][src_head[i]] : 1'b0;
`endif
    end
    m_ready = stall_mode ? pat[cyc % 4] : 1'b1;
  endtask

  // Observe the handshakes that will complete at the coming rising edge.
  task automatic sample();
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_data", 32'(m_if.data), 32'(prev_data));
        chk("hold_valid", 32'(m_if.valid), 32'd1);
      end
      if (cpv && m_if.valid && !m_ready) begin
        nstall++;
        chk("stall_ready", 32'(tb_ready[curr_path]), 32'd0);
      end
      prev_stall = m_if.valid && !m_ready;
      prev_data  = m_if.data;
      if (clk_en) begin
        if (m_if.valid && m_ready) begin
          chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) chk("data", 32'(m_if.data), 32'(sb.pop_front()));
`ifdef DATA_PIPE_ARB_LAST_EN
          if (sb_last.size() != 0) chk("m_last", 32'(m_last), 32'(sb_last.pop_front()));
`endif
          ndn++;
        end
        for (int i = 0; i < NUM; i++) begin
          if (tb_valid[i] && tb_ready[i]) begin
            chk("owner_path", 32'(curr_path), 32'(i));
            sb.push_back(tb_data[i]);
`ifdef DATA_PIPE_ARB_LAST_EN
            sb_last.push_back(tb_last[i]);
`endif
            own_log.push_back(i);
            cyc_log.push_back(cyc);
            src_head[i]++;
          end
        end
      end
      if (int'(burst_cnt) > max_bc) max_bc = int'(burst_cnt);
    end
  endtask

  task automatic tick();
    sample();
    @(posedge clock);
    #1;
    cyc++;
    drive();
    @(negedge clock);
  endtask

  function automatic bit busy();
    bit b;
    b = (sb.size() != 0) || m_if.valid;
    for (int i = 0; i < NUM; i++) b = b || (src_head[i] < src_len[i]);
    return b;
  endfunction

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (busy() && n < max_cyc) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("drain_done", 32'(busy()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(tb_ready), 32'd0);
    chk({tag, "_mvalid"}, 32'(m_if.valid), 32'd0);
    chk({tag, "_mdata"}, 32'(m_if.data), 32'd0);
    chk({tag, "_cpv"}, 32'(cpv), 32'd0);
    chk({tag, "_path"}, 32'(curr_path), 32'd0);
    chk({tag, "_bcnt"}, 32'(burst_cnt), 32'd0);
  endtask

  initial begin
    int lat, n;
    for (int i = 0; i < NUM; i++) begin
      src_head[i] = 0;
      src_len[i]  = 0;
    end
    drive();
    @(negedge clock);

    // Test 1: reset with nothing requesting, then stay idle.
    repeat (3) tick();
    chk_reset_outputs("t1_rst");
    rst = 1'b0;
    repeat (3) tick();
    chk("t1_idle_cpv", 32'(cpv), 32'd0);
    chk("t1_idle_ready", 32'(tb_ready), 32'd0);

`ifndef DATA_PIPE_ARB_LAST_EN
    // Test 2: requester 2 alone with five beats. MAX_BURST=4 forces one re-grant.
    ndn = 0;
    load(2, 5, 8'h10);
    tick();
    lat = 0;
    while (!tb_ready[2] && lat < 10) begin
      tick();
      lat++;
    end
    chk("t2_grant_latency", 32'(lat), 32'd2);
    drain(100);
    chk("t2_beats", 32'(ndn), 32'd5);
    chk("t2_path_held", 32'(curr_path), 32'd2);
    chk("t2_released", 32'(cpv), 32'd0);

    // Test 3: all four continuously valid after reset -> order 0,1,2,3,0,...
    rst = 1'b1;
    tick();
    rst = 1'b0;
    own_log.delete();
    cyc_log.delete();
    max_bc = 0;
    for (int r = 0; r < NUM; r++) load(r, 8, 8'(8'h40 + 8'(r * 16)));
    drain(300);
    chk("t3_beats", 32'(own_log.size()), 32'd32);
    for (int k = 0; k < own_log.size(); k++) begin
      chk("t3_order", 32'(own_log[k]), 32'((k / 4) % 4));
      if (k > 0) chk("t3_gap", 32'(cyc_log[k] - cyc_log[k-1]), (k % 4 == 0) ? 32'd3 : 32'd1);
    end
    chk("t3_max_burst", 32'(max_bc), 32'd4);

    // Test 4: downstream stalls 1,0,0,1 during a grant.
    ndn = 0;
    nstall = 0;
    stall_mode = 1'b1;
    load(1, 6, 8'hA0);
    drain(200);
    stall_mode = 1'b0;
    chk("t4_beats", 32'(ndn), 32'd6);
    chk("t4_stalls_seen", 32'(nstall > 0), 32'd1);

    // Test 5: reset mid-burst at burst_cnt=3, then requester 0 wins over 3.
    load(3, 10, 8'hC0);
    n = 0;
    while (burst_cnt !== 16'd3 && n < 50) begin
      tick();
      n++;
    end
    chk("t5_reach3", 32'(burst_cnt), 32'd3);
    load(0, 2, 8'hE0);
    own_log.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk_reset_outputs("t5_rst");
    drain(200);
    chk("t5_first_owner", (own_log.size() != 0) ? 32'(own_log[0]) : 32'hFFFF, 32'd0);

    // clk_en low in GRANT freezes the counter but keeps the ready value.
    load(1, 3, 8'h30);
    n = 0;
    while (!cpv && n < 20) begin
      tick();
      n++;
    end
    chk("ce_granted", 32'(cpv), 32'd1);
    clk_en = 1'b0;
    repeat (4) tick();
    chk("ce_bcnt_frozen", 32'(burst_cnt), 32'd0);
    chk("ce_cpv_frozen", 32'(cpv), 32'd1);
    chk("ce_ready_kept", 32'(tb_ready[1]), 32'd1);
    chk("ce_mvalid", 32'(m_if.valid), 32'd0);
    clk_en = 1'b1;
    drain(100);
    chk("ce_bcnt_final", 32'(burst_cnt), 32'd3);
    chk("ce_released", 32'(cpv), 32'd0);
`else
    // Test 6: 20-beat packet from requester 1 is never split, then requester 2.
    own_log.delete();
    cyc_log.delete();
    load(1, 20, 8'h80);
    load(2, 2, 8'h90);
    drain(300);
    chk("t6_beats", 32'(own_log.size()), 32'd22);
    for (int k = 0; k < 20 && k < own_log.size(); k++) begin
      chk("t6_owner", 32'(own_log[k]), 32'd1);
      if (k > 0) chk("t6_gap", 32'(cyc_log[k] - cyc_log[k-1]), 32'd1);
    end
    chk("t6_next_owner", (own_log.size() > 20) ? 32'(own_log[20]) : 32'hFFFF, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
